or_nway_pipe: RTL and testbench
===============================

# or_nway_pipe

Parametrised, pipelined N-input reduction unit, the successor to the combinational 8-way OR gate in the gate library. It reduces a WIDTH-bit vector through a registered FANIN-ary tree and supports OR, AND, XOR and NOR per sample. It also carries a valid/stall handshake, a sticky result accumulator and a saturating hit counter. It serves as the flag and zero-detect reducer in the ALU and CPU status path, where an un-pipelined wide OR would limit clock rate.

## Interface
- WIDTH, 8: number of input bits, ≥1.
- FANIN, 2: inputs per tree node, ≥2.
- CNT_W, 8: hit counter width.
- LEVELS (localparam): max(1, ceil(log_FANIN(WIDTH))). For WIDTH=8, FANIN=2 this is 3.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  pipeline advance; 0 stalls the whole block.
- in_valid  in  1  in_data and op are valid this cycle.
- in_data  in  WIDTH  vector to reduce.
- op  in  2  operation: 00 OR, 01 AND, 10 XOR, 11 NOR.
- acc_clr  in  1  clear the sticky accumulator and the hit counter.
- out_valid  out  1  out_bit holds a new result.
- out_bit  out  1  reduction result.
- acc_bit  out  1  sticky OR of all results since the last clear or reset.
- hit_cnt  out  CNT_W  count of valid results with out_bit=1, saturating.

## Operation
- Tree structure:
  - Level 0 groups in_data into ceil(WIDTH/FANIN) nodes; each later level groups the previous level's nodes by FANIN.
  - Each level's outputs are registered, so there are LEVELS register stages.
- Padding: missing leaves in a partial group take the identity element, 0 for OR/XOR/NOR and 1 for AND. WIDTH therefore need not be a power of FANIN.
- Operation selection:
  - op is registered alongside the data at every stage, so each sample is reduced with the op sampled with it. Changing op between consecutive samples is legal and has no cross-effect.
  - NOR is computed as an OR through the tree, with inversion applied only when the final stage is loaded.
- Valid handling: a valid bit travels with each stage. A stage with valid=0 still loads data, but its result is never flagged.
- Stall: with en=0, every pipeline register, out_valid, out_bit, acc_bit and hit_cnt hold their values, and in_valid is ignored.
- Accumulator: on an edge with en=1 where the final stage loads valid=1, the update is acc_bit ← acc_bit | result.
  - hit_cnt increments when result=1 and saturates at 2^CNT_W−1 without wrapping.
- acc_clr (sampled every edge, regardless of en):
  - With no simultaneous final-stage load, acc_bit ← 0 and hit_cnt ← 0.
  - If a valid result loads on the same edge, acc_bit ← result and hit_cnt ← result. The new result is kept and the old history is dropped.
- Reset:
  - Clears all stage valid bits, all data registers (to 0) and op registers (to OR).
  - Drives out_valid=0, out_bit=0, acc_bit=0, hit_cnt=0 immediately, without waiting for a clock edge.
  - Reset during operation discards every in-flight sample; no result from before reset ever appears at the outputs.

## Timing
- Latency: a sample accepted at edge N (en=1, in_valid=1) appears with out_valid=1 after edge N+LEVELS−1, counting only edges with en=1. Each stalled edge adds one cycle.
- Throughput: one sample per enabled cycle with no bubbles.
- out_valid pulse length: one enabled cycle per sample. It stays high across a stall, since outputs hold.
- acc_bit and hit_cnt reflect a result in the same cycle in which out_valid first shows it.
- WIDTH=1: LEVELS=1, so latency is one edge and out_bit is in_data, or its inverse for NOR.
- Open-ended stalls are legal; the block has no internal timeout.

## Test plan
- WIDTH=8, FANIN=2, op=OR: apply 0x00, 0x01, 0x64, 0xFF, 0x4A on consecutive cycles.
  - out_bit must be 0,1,1,1,1, starting 3 cycles later with out_valid high for 5 cycles.
  - acc_bit must rise with the second result; hit_cnt must end at 4.
- Per-sample op change: drive 0xFF with AND, then 0xFE with AND, then 0x07 with XOR, then 0x00 with NOR.
  - out_bit must be 1,0,1,1 in order.
- WIDTH=5, FANIN=4 (LEVELS=2), testing the padding identity: 5'b11111 with AND must give 1; 5'b10000 with OR must give 1; 5'b00000 with OR must give 0.
- Stall: hold en=0 for 4 cycles while two samples are in flight.
  - No output change and no hit_cnt change during the stall.
  - Both results emerge after en returns, with total latency of 3+4 cycles.
- acc_clr together with a valid result of 1 must give acc_bit=1 and hit_cnt=1.
  - Then, with CNT_W=2, feed 5 ones: hit_cnt must saturate at 3.
- Assert rst asynchronously with 3 samples in flight.
  - Outputs must go to 0 before the next edge.
  - After release, no stale out_valid may appear, and a new sample must emerge after exactly 3 cycles.

Source files
------------

// File: rtl/or_nway_pipe.sv
// or_nway_pipe
//   Pipelined WIDTH-input reduction (OR / AND / XOR / NOR) built as a registered
//   FANIN-ary tree, with a valid/stall handshake, a sticky result accumulator
//   and a saturating hit counter.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         pipeline advance; 0 freezes every register in the block
//   in_valid   in_data/op carry a sample this cycle
//   in_data    WIDTH-bit vector to reduce
//   op         00 OR, 01 AND, 10 XOR, 11 NOR
//   acc_clr    clear accumulator and hit counter (acts on every edge)
//   out_valid  out_bit holds a new result
//   out_bit    reduction result
//   acc_bit    sticky OR of results since last clear/reset
//   hit_cnt    saturating count of valid results equal to 1
module or_nway_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FANIN = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    output logic             out_bit,
    output logic             acc_bit,
    output logic [CNT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    // Number of nodes left after k reduction levels (k = 0 gives WIDTH).
    function automatic int unsigned level_nodes(input int unsigned w,
                                                input int unsigned f,
                                                input int unsigned k);
        int unsigned n;
        n = w;
        for (int unsigned i = 0; i < k; i++) begin
            n = (n + f - 1) / f;
        end
        return n;
    endfunction

    // max(1, ceil(log_f(w)))
    function automatic int unsigned calc_levels(input int unsigned w,
                                                input int unsigned f);
        int unsigned n;
        int unsigned c;
        n = w;
        c = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (n > 1) begin
                n = (n + f - 1) / f;
                c = c + 1;
            end
        end
        return (c == 0) ? 1 : c;
    endfunction

    localparam int unsigned LEVELS = calc_levels(WIDTH, FANIN);

    logic res_next;   // value the final stage loads on this edge
    logic res_load;   // final stage loads a valid result on this edge

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned NIN  = level_nodes(WIDTH, FANIN, l);
        localparam int unsigned NOUT = level_nodes(WIDTH, FANIN, l + 1);

        logic [NIN-1:0]        src_d;
        op_e                   src_op;
        logic                  src_v;
        logic [NOUT*FANIN-1:0] pad;
        logic [NOUT-1:0]       red;
        logic [NOUT-1:0]       d_next;
        logic [NOUT-1:0]       d_q;
        logic                  v_q;

        if (l == 0) begin : g_src
            assign src_d  = in_data;
            assign src_op = op_e'(op);
            assign src_v  = in_valid;
        end else begin : g_src
            assign src_d  = g_lvl[l-1].d_q;
            assign src_op = g_lvl[l-1].g_op.op_q;
            assign src_v  = g_lvl[l-1].v_q;
        end

        // Leaves beyond the last real input take the identity of the op:
        // 1 for AND, 0 otherwise (NOR travels as OR).
        for (genvar k = 0; k < NOUT * FANIN; k++) begin : g_pad
            if (k < NIN) begin : g_real
                assign pad[k] = src_d[k];
            end else begin : g_ident
                assign pad[k] = (src_op == OP_AND);
            end
        end

        for (genvar j = 0; j < NOUT; j++) begin : g_node
            logic [FANIN-1:0] grp;
            assign grp    = pad[j*FANIN +: FANIN];
            assign red[j] = (src_op == OP_AND) ? (&grp) :
                            (src_op == OP_XOR) ? (^grp) : (|grp);
        end

        // NOR is reduced as OR and inverted only when the last stage loads.
        if (l == LEVELS - 1) begin : g_fin
            assign d_next = (src_op == OP_NOR) ? ~red : red;
        end else begin : g_mid
            assign d_next = red;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d_q <= '0;
                v_q <= 1'b0;
            end else if (en) begin
                d_q <= d_next;
                v_q <= src_v;
            end
        end

        // The op only needs to travel to the stages that still reduce.
        if (l < LEVELS - 1) begin : g_op
            op_e op_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    op_q <= OP_OR;
                end else if (en) begin
                    op_q <= src_op;
                end
            end
        end
    end

    assign out_bit   = g_lvl[LEVELS-1].d_q[0];
    assign out_valid = g_lvl[LEVELS-1].v_q;
    assign res_next  = g_lvl[LEVELS-1].d_next[0];
    assign res_load  = en & g_lvl[LEVELS-1].src_v;

    // A clear coinciding with a valid load keeps the new result and drops
    // the old history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_bit <= 1'b0;
            hit_cnt <= '0;
        end else if (acc_clr) begin
            acc_bit <= res_load & res_next;
            hit_cnt <= CNT_W'(res_load & res_next);
        end else if (res_load) begin
            acc_bit <= acc_bit | res_next;
            if (res_next && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_or_nway_pipe.sv
module tb_or_nway_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] op;
    logic       acc_clr;

    logic       ov [3];
    logic       ob [3];
    logic       ab [3];
    logic [7:0] hc8;
    logic [7:0] hc5;
    logic [1:0] hc2;
    logic [7:0] hcx [3];

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    or_nway_pipe #(.WIDTH(8), .FANIN(2), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
        .op(op), .acc_clr(acc_clr), .out_valid(ov[0]), .out_bit(ob[0]),
        .acc_bit(ab[0]), .hit_cnt(hc8)
    );

    or_nway_pipe #(.WIDTH(5), .FANIN(4), .CNT_W(8)) u_dut5 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data[4:0]),
        .op(op), .acc_clr(acc_clr), .out_valid(ov[1]), .out_bit(ob[1]),
        .acc_bit(ab[1]), .hit_cnt(hc5)
    );

    or_nway_pipe #(.WIDTH(8), .FANIN(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
        .op(op), .acc_clr(acc_clr), .out_valid(ov[2]), .out_bit(ob[2]),
        .acc_bit(ab[2]), .hit_cnt(hc2)
    );

    assign hcx[0] = hc8;
    assign hcx[1] = hc5;
    assign hcx[2] = {6'b0, hc2};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference reduction over the low w bits of v.
    function automatic logic model_reduce(input logic [7:0] v, input int unsigned w,
                                          input logic [1:0] o);
        logic [7:0] m;
        m = (w >= 8) ? 8'hFF : 8'((32'd1 << w) - 32'd1);
        case (o)
            2'b00:   return |(v & m);
            2'b01:   return &(v | ~m);
            2'b10:   return ^(v & m);
            default: return ~|(v & m);
        endcase
    endfunction

    // Per-DUT scoreboard: each accepted sample is pushed with the enabled-edge
    // index at which it must appear.
    typedef struct {
        int unsigned due;
        logic        r;
    } exp_t;

    exp_t        sbq [3][$];
    int unsigned mw   [3] = '{8, 5, 8};
    int unsigned ml   [3] = '{3, 2, 3};
    int unsigned mmax [3] = '{255, 255, 3};
    int unsigned ecount [3] = '{0, 0, 0};
    logic        eov  [3] = '{1'b0, 1'b0, 1'b0};
    logic        eob  [3] = '{1'b0, 1'b0, 1'b0};
    logic        eacc [3] = '{1'b0, 1'b0, 1'b0};
    int unsigned ecnt [3] = '{0, 0, 0};

    logic       c_en, c_v, c_clr, c_rst;
    logic [7:0] c_d;
    logic [1:0] c_op;

    task automatic model_step(input int i);
        exp_t e;
        logic ld;
        logic r;
        ld = 1'b0;
        r  = 1'b0;
        if (c_rst) begin
            sbq[i].delete();
            ecount[i] = 0;
            eov[i] = 1'b0;
            eob[i] = 1'b0;
            eacc[i] = 1'b0;
            ecnt[i] = 0;
        end else begin
            if (c_en) begin
                ecount[i]++;
                if (c_v) begin
                    e.due = ecount[i] + ml[i] - 1;
                    e.r   = model_reduce(c_d, mw[i], c_op);
                    sbq[i].push_back(e);
                end
                if (sbq[i].size() > 0 && sbq[i][0].due == ecount[i]) begin
                    e = sbq[i].pop_front();
                    ld = 1'b1;
                    r  = e.r;
                    eov[i] = 1'b1;
                    eob[i] = r;
                end else begin
                    eov[i] = 1'b0;
                end
            end
            if (c_clr) begin
                eacc[i] = ld & r;
                ecnt[i] = (ld && r) ? 1 : 0;
            end else if (ld) begin
                eacc[i] = eacc[i] | r;
                if (r && ecnt[i] < mmax[i]) ecnt[i]++;
            end
        end
        check_eq($sformatf("d%0d_out_valid", i), 32'(ov[i]), 32'(eov[i]));
        if (eov[i]) check_eq($sformatf("d%0d_out_bit", i), 32'(ob[i]), 32'(eob[i]));
        check_eq($sformatf("d%0d_acc_bit", i), 32'(ab[i]), 32'(eacc[i]));
        check_eq($sformatf("d%0d_hit_cnt", i), 32'(hcx[i]), ecnt[i]);
    endtask

    always begin
        @(posedge clk);
        c_en  = en;
        c_v   = in_valid;
        c_d   = in_data;
        c_op  = op;
        c_clr = acc_clr;
        c_rst = rst;
        #1;
        for (int i = 0; i < 3; i++) model_step(i);
    end

    task automatic drive(input logic e, input logic v, input logic [7:0] d,
                         input logic [1:0] o, input logic c);
        en = e; in_valid = v; in_data = d; op = o; acc_clr = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("%s_d%0d_ov", tag, i), 32'(ov[i]), 32'd0);
            check_eq($sformatf("%s_d%0d_ob", tag, i), 32'(ob[i]), 32'd0);
            check_eq($sformatf("%s_d%0d_ab", tag, i), 32'(ab[i]), 32'd0);
            check_eq($sformatf("%s_d%0d_hc", tag, i), 32'(hcx[i]), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0; op = '0; acc_clr = 1'b0;
        #2;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // OR stream
        drive(1, 1, 8'h00, 2'b00, 0);
        drive(1, 1, 8'h01, 2'b00, 0);
        drive(1, 1, 8'h64, 2'b00, 0);
        drive(1, 1, 8'hFF, 2'b00, 0);
        drive(1, 1, 8'h4A, 2'b00, 0);
        idle(4);
        check_eq("or_stream_hit", 32'(hc8), 32'd4);
        check_eq("or_stream_acc", 32'(ab[0]), 32'd1);

        // clear with an empty pipeline
        drive(1, 0, 8'h00, 2'b00, 1);
        check_eq("clr_acc", 32'(ab[0]), 32'd0);
        check_eq("clr_hit", 32'(hc8), 32'd0);

        // per-sample op change
        drive(1, 1, 8'hFF, 2'b01, 0);
        drive(1, 1, 8'hFE, 2'b01, 0);
        drive(1, 1, 8'h07, 2'b10, 0);
        drive(1, 1, 8'h00, 2'b11, 0);
        idle(4);

        // padding identity (meaningful for the 5-input, fan-in 4 instance)
        drive(1, 1, 8'h1F, 2'b01, 0);
        drive(1, 1, 8'h10, 2'b00, 0);
        drive(1, 1, 8'h00, 2'b00, 0);
        drive(1, 1, 8'h10, 2'b11, 0);
        idle(4);

        // stall with two samples in flight; in_valid during stall is ignored
        drive(1, 1, 8'h80, 2'b00, 0);
        drive(1, 1, 8'h00, 2'b11, 0);
        for (int k = 0; k < 4; k++) drive(0, 1, 8'hFF, 2'b01, 0);
        idle(5);

        // clear coinciding with a valid result of 1 on the 8-input instance
        drive(1, 1, 8'h01, 2'b00, 0);
        idle(1);
        drive(1, 0, 8'h00, 2'b00, 1);
        check_eq("clr_load_acc", 32'(ab[0]), 32'd1);
        check_eq("clr_load_hit", 32'(hc8), 32'd1);
        for (int k = 0; k < 5; k++) drive(1, 1, 8'h01, 2'b00, 0);
        idle(4);
        check_eq("sat_hit", 32'(hc2), 32'd3);
        check_eq("nosat_hit", 32'(hc8), 32'd6);

        // asynchronous reset with samples in flight
        drive(1, 1, 8'hFF, 2'b00, 0);
        drive(1, 1, 8'hFF, 2'b00, 0);
        drive(1, 1, 8'hFF, 2'b00, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        drive(1, 1, 8'h01, 2'b00, 0);
        idle(4);

        for (int i = 0; i < 3; i++)
            check_eq($sformatf("d%0d_drain", i), sbq[i].size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
